// File: rtl/pht_sched_pkg.sv
// Shared types, FSM state codes and the saturating-counter helper for the
// PHT access scheduler.
package pht_sched_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_RD_WAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_WR      = 2'd2;

    localparam int unsigned PHT_IDX_W = 6;

    // Update entry layout at the default index width
    typedef struct packed {
        logic [PHT_IDX_W-1:0] idx;
        logic                 taken;
    } upd_entry_t;

    // 2-bit saturating counter step
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != 2'b11) res = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/pht_access_scheduler_fifo.sv
// Small synchronous FIFO buffering resolved-branch updates.
// head_c shows the oldest entry; push is ignored when full, pop when empty.
module pht_upd_fifo #(
    parameter int unsigned W     = 7,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head_c,
    output logic         full_c,
    output logic         empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointers carry one wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full_c) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty_c) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (push && !full_c) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign head_c  = mem[rd_ptr[AW-1:0]];
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/pht_access_scheduler.sv
// PHT access scheduler: shares one single-port PHT between prediction lookups
// (priority) and buffered read-modify-write updates with a bounded wait.
// Optional macro PHT_FWD_EN: lookups hitting the address of an update waiting
// to write return the pending new value instead of the stale table contents.
module pht_access_scheduler
    import pht_sched_pkg::*;
#(
    parameter int unsigned IDX_W        = 6,
    parameter int unsigned UPD_DEPTH    = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_req,
    input  logic [IDX_W-1:0] pred_idx,
    output logic             pred_ready,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             upd_busy,
    output logic             pht_en,
    output logic             pht_we,
    output logic [IDX_W-1:0] pht_addr,
    output logic [1:0]       pht_wdata,
    input  logic [1:0]       pht_rdata
);

    localparam int unsigned ENT_W = IDX_W + 1;
    localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } entry_t;

    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;
    logic [SC_W-1:0] starve_cnt;
    entry_t          fifo_head_c;
    entry_t          fifo_wdata_c;
    logic            fifo_full_c;
    logic            fifo_empty_c;
    logic            fifo_push_c;
    logic            fifo_pop_c;
    logic            want_c;
    logic            lookup_go_c;
    logic            upd_go_c;
    logic            pred_bit_c;
    logic [IDX_W-1:0] hold_idx;
    logic            hold_taken;
    logic [1:0]      hold_val;
    logic            rd_owner;

    assign fifo_wdata_c = '{idx: upd_idx, taken: upd_taken};

    pht_upd_fifo #(
        .W     (ENT_W),
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push_c),
        .wdata   (fifo_wdata_c),
        .pop     (fifo_pop_c),
        .head_c  (fifo_head_c),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Port arbitration, PHT port drive and next-state logic
    always_comb begin
        state_nxt   = state;
        want_c      = ((state == ST_IDLE) && !fifo_empty_c) || (state == ST_WR);
        pred_ready  = !(want_c && (starve_cnt == SC_W'(STARVE_LIMIT)));
        lookup_go_c = pred_req && pred_ready;
        upd_go_c    = want_c && !lookup_go_c;
        fifo_push_c = upd_valid && !fifo_full_c;
        fifo_pop_c  = upd_go_c && (state == ST_IDLE);
        upd_ready   = !fifo_full_c;
        upd_busy    = !fifo_empty_c || (state != ST_IDLE);
        pht_en      = lookup_go_c || upd_go_c;
        pht_we      = upd_go_c && (state == ST_WR);
        pht_wdata   = hold_val;
        pht_addr    = fifo_head_c.idx;
        if (lookup_go_c)          pht_addr = pred_idx;
        else if (state == ST_WR)  pht_addr = hold_idx;
        case (state)
            ST_IDLE:    if (upd_go_c) state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: state_nxt = ST_WR;
            ST_WR:      if (upd_go_c) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Update hold registers: head captured at pop, new value computed on read return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_idx   <= '0;
            hold_taken <= 1'b0;
            hold_val   <= 2'b00;
        end else begin
            if (fifo_pop_c) begin
                hold_idx   <= fifo_head_c.idx;
                hold_taken <= fifo_head_c.taken;
            end
            if (state == ST_RD_WAIT) hold_val <= sat_update(pht_rdata, hold_taken);
        end
    end

    // Starvation counter: consecutive cycles the update wanted the port and lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   starve_cnt <= '0;
        else if (want_c && !upd_go_c) starve_cnt <= starve_cnt + SC_W'(1);
        else                          starve_cnt <= '0;
    end

`ifdef PHT_FWD_EN
    logic fwd_hit;
    logic fwd_bit;

    // Record a lookup that hits the address of the update waiting to write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit <= 1'b0;
            fwd_bit <= 1'b0;
        end else begin
            fwd_hit <= lookup_go_c && (state == ST_WR) && (pred_idx == hold_idx);
            fwd_bit <= hold_val[1];
        end
    end

    assign pred_bit_c = fwd_hit ? fwd_bit : pht_rdata[1];
`else
    assign pred_bit_c = pht_rdata[1];
`endif

    // Read ownership and registered prediction result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner   <= 1'b0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
        end else begin
            rd_owner   <= lookup_go_c;
            pred_valid <= rd_owner;
            pred_taken <= rd_owner && pred_bit_c;
        end
    end

endmodule
